data_memory_sized: RTL and testbench

- Parametrised successor of the single-cycle data memory for the MIPS32 datapath.
- Byte-addressed, word-organised RAM with MIPS load/store sizes (LB/LBU/LH/LHU/LW, SB/SH/SW) and byte-lane writes.
- Valid/ready request handshake with one-cycle registered read latency.
- Reports alignment and range faults, and zero-clears its contents after reset with a sweep state machine.
- Sits between the ALU address path and the writeback mux.

---
 rtl/mips_mem_pkg.sv | 51 +++++
 rtl/data_memory_sized_if.sv | 29 ++
 rtl/data_memory_sized_ram.sv | 42 ++++
 rtl/data_memory_sized.sv | 158 +++++++++++++++
 tb/tb_data_memory_sized.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the sized MIPS data memory.
// Holds size encodings, FSM states, byte-enable and load-extension helpers.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Lanes are little-endian: lane 0 is bits [7:0].
    function automatic logic [3:0] byte_en(size_e sz, logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = 4'b0011 << lane;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extract(
        logic [31:0] word,
        size_e       sz,
        logic [1:0]  lane,
        logic        uns
    );
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {lane, 3'b000};
        res = 32'h0;
        case (sz)
            SZ_BYTE: res = uns ? {24'h0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: res = uns ? {16'h0, sh[15:0]}
                               : {{16{sh[15]}}, sh[15:0]};
            SZ_WORD: res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_memory_sized_if.sv
// Request/response bundle for data_memory_sized.
// master: datapath side (drives req_*); slave: memory side (drives resp_*, req_ready, busy).
interface data_memory_sized_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_size, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, busy
    );
endinterface

// File: rtl/data_memory_sized_ram.sv
// DEPTH_WORDS x 32 storage, byte-enable synchronous write, registered read.
// Ports: clk, we/be/wdata (write), re (read strobe), idx (word), rdata (registered).
module mem_lane_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    input  logic             re,
    output logic [31:0]      rdata
);
    import mips_mem_pkg::*;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && be[b]) begin
                mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[idx];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_sized.sv
// Sized MIPS data memory: LB/LBU/LH/LHU/LW, SB/SH/SW, fault reporting, clear sweep.
// Ports: clk, reset (sync, active-high), bus (slave side of data_memory_sized_if).
module data_memory_sized #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int ADDR_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_sized_if.slave  bus
);
    import mips_mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             rsp_v_q, rsp_v_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_wr_q, rsp_wr_d;
    logic             rsp_uns_q, rsp_uns_d;
    size_e            rsp_sz_q, rsp_sz_d;
    logic [1:0]       rsp_lane_q, rsp_lane_d;

    size_e            sz;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic             hi_fault;
    logic             fault;
    logic             ready;
    logic             accept;

    logic             ram_we;
    logic [3:0]       ram_be;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      ram_wdata;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    assign sz   = size_e'(bus.req_size);
    assign lane = bus.req_addr[1:0];
    assign idx  = bus.req_addr[IDX_W+1:2];

    // Address bits above the word index must be clear, else the
    // request would silently alias a lower word.
    generate
        if (ADDR_WIDTH > IDX_W + 2) begin : g_hi
            assign hi_fault = |bus.req_addr[ADDR_WIDTH-1:IDX_W+2];
        end else begin : g_nohi
            assign hi_fault = 1'b0;
        end
    endgenerate

    always_comb begin
        fault = 1'b0;
        case (sz)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = lane[0];
            SZ_WORD: fault = (lane != 2'b00);
            default: fault = 1'b1;
        endcase
        fault = fault | hi_fault;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        accept    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_idx   = idx;
        ram_wdata = 32'h0;
        ram_re    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                ram_we  = 1'b1;
                ram_be  = 4'b1111;
                ram_idx = cnt_q;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                ready  = ~reset;
                accept = bus.req_valid & ready;
                if (accept && bus.req_write && !fault) begin
                    ram_we = 1'b1;
                    ram_be = byte_en(sz, lane);
                    case (sz)
                        SZ_BYTE: ram_wdata = {4{bus.req_wdata[7:0]}};
                        SZ_HALF: ram_wdata = {2{bus.req_wdata[15:0]}};
                        default: ram_wdata = bus.req_wdata;
                    endcase
                end
                ram_re = accept & ~bus.req_write;
            end
        endcase
    end

    always_comb begin
        rsp_v_d    = accept;
        rsp_err_d  = accept & fault;
        rsp_wr_d   = accept & bus.req_write;
        rsp_uns_d  = bus.req_unsigned;
        rsp_sz_d   = sz;
        rsp_lane_d = lane;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            cnt_q      <= '0;
            rsp_v_q    <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_wr_q   <= 1'b0;
            rsp_uns_q  <= 1'b0;
            rsp_sz_q   <= SZ_BYTE;
            rsp_lane_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rsp_v_q    <= rsp_v_d;
            rsp_err_q  <= rsp_err_d;
            rsp_wr_q   <= rsp_wr_d;
            rsp_uns_q  <= rsp_uns_d;
            rsp_sz_q   <= rsp_sz_d;
            rsp_lane_q <= rsp_lane_d;
        end
    end

    mem_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    // Outputs are gated by reset so a response in flight when reset
    // arrives is never presented.
    assign bus.req_ready  = ready;
    assign bus.busy       = reset ? CLEAR_ON_RESET
                                  : (state_q == ST_CLEAR);
    assign bus.resp_valid = rsp_v_q & ~reset;
    assign bus.resp_error = rsp_v_q & rsp_err_q & ~reset;
    assign bus.resp_rdata =
        (rsp_v_q && !reset && !rsp_err_q && !rsp_wr_q)
            ? load_extract(ram_rdata, rsp_sz_q, rsp_lane_q, rsp_uns_q)
            : 32'h0;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DEPTH_WORDS=16, CLEAR_ON_RESET=1).
// Drives requests on negedges and checks responses on the following negedge.
module tb_data_memory_sized;

    localparam int DEPTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_busy;
    logic ready_seen;

    always #5 clk = ~clk;

    data_memory_sized_if #(.ADDR_WIDTH(32)) bus ();

    data_memory_sized #(
        .DEPTH_WORDS    (DEPTH),
        .ADDR_WIDTH     (32),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_d,
                       input logic exp_e, input string tag);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'h1);
        chk({tag, "_rdata"}, bus.resp_rdata, exp_d);
        chk({tag, "_error"}, 32'(bus.resp_error), 32'(exp_e));
    endtask

    task automatic count_busy(output int n, output logic rdy);
        n   = 0;
        rdy = 1'b0;
        while (bus.busy && n < 200) begin
            n++;
            if (bus.req_ready) rdy = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rvalid", 32'(bus.resp_valid), 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_rerror", 32'(bus.resp_error), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;

        count_busy(n_busy, ready_seen);
        chk("sweep_len", 32'(n_busy), 32'(DEPTH));
        chk("sweep_ready", 32'(ready_seen), 32'h0);
        chk("run_ready", 32'(bus.req_ready), 32'h1);

        req(0, 2'b10, 0, 32'h3C, 0, 32'h0, 0, "lw_3c_clear");

        req(1, 2'b10, 0, 32'h08, 32'h80FF7F01, 32'h0, 0, "sw_08");
        req(0, 2'b00, 0, 32'h08, 0, 32'h00000001, 0, "lb_08");
        req(0, 2'b00, 0, 32'h09, 0, 32'h0000007F, 0, "lb_09");
        req(0, 2'b00, 0, 32'h0A, 0, 32'hFFFFFFFF, 0, "lb_0a");
        req(0, 2'b00, 1, 32'h0A, 0, 32'h000000FF, 0, "lbu_0a");
        req(0, 2'b01, 0, 32'h0A, 0, 32'hFFFF80FF, 0, "lh_0a");
        req(0, 2'b01, 1, 32'h0A, 0, 32'h000080FF, 0, "lhu_0a");
        req(0, 2'b01, 0, 32'h08, 0, 32'h00007F01, 0, "lh_08");

        req(1, 2'b10, 0, 32'h0C, 32'h11223344, 32'h0, 0, "sw_0c");
        req(1, 2'b00, 0, 32'h0D, 32'h000000AB, 32'h0, 0, "sb_0d");
        req(0, 2'b10, 0, 32'h0C, 0, 32'h1122AB44, 0, "lw_0c");
        req(1, 2'b01, 0, 32'h0E, 32'hFFFF5566, 32'h0, 0, "sh_0e");
        req(0, 2'b10, 0, 32'h0C, 0, 32'h5566AB44, 0, "lw_0c_sh");

        req(1, 2'b10, 0, 32'h04, 32'hCAFEF00D, 32'h0, 0, "sw_04");
        req(0, 2'b01, 0, 32'h05, 0, 32'h0, 1, "lh_05_mis");
        req(1, 2'b10, 0, 32'h06, 32'hDEADDEAD, 32'h0, 1, "sw_06_mis");
        req(0, 2'b10, 0, 32'h04, 0, 32'hCAFEF00D, 0, "lw_04_keep");
        req(0, 2'b11, 0, 32'h00, 0, 32'h0, 1, "rsvd_size");
        req(0, 2'b10, 0, 32'h40, 0, 32'h0, 1, "lw_40_range");
        req(1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 1, "sw_40_range");
        req(0, 2'b10, 0, 32'h00, 0, 32'h0, 0, "lw_00_noalias");

        req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10");
        req(0, 2'b10, 0, 32'h10, 0, 32'hDEADBEEF, 0, "lw_10_fwd");

        @(negedge clk);
        chk("idle_rvalid", 32'(bus.resp_valid), 32'h0);
        chk("idle_rdata", bus.resp_rdata, 32'h0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_sweep_busy", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        count_busy(n_busy, ready_seen);
        chk("resweep_len", 32'(n_busy), 32'(DEPTH));
        chk("resweep_ready", 32'(ready_seen), 32'h0);
        req(0, 2'b10, 0, 32'h10, 0, 32'h0, 0, "lw_10_cleared");
        req(0, 2'b10, 0, 32'h0C, 0, 32'h0, 0, "lw_0c_cleared");

        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h04;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_drop_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_drop_rdata", bus.resp_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_after_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_after_busy", 32'(bus.busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
